// File: rtl/gpio_cmd_responder.sv
// gpio_cmd_responder
// Serves simple commands posted by a processor over a pair of GPIO words,
// using a four-phase request/ack handshake.
//   i_clk      : single clock for all logic
//   i_reset    : asynchronous, active-low reset
//   i_gpo      : command word [31:24] opcode, [23] request, [22:0] write data
//   o_gpi      : response word [31] ack, [30] error, [29:23] zero, [22:0] read data
//   i_sw       : board switches, sampled only by the switch-read command
//   o_leds_rgb : LED register bits [11:0] ({rgb3,rgb2,rgb1,rgb0})
//   o_leds     : LED register bits [13:12] (mono LEDs)
// Opcodes: 0x01 LED write, 0x02 switch read, 0x03 counter snapshot,
//          0x04 snapshot high bits, 0x05 counter clear, others -> error.
module gpio_cmd_responder #(
  parameter int NB_GPIOS    = 32,
  parameter int NB_SWITCHES = 4,
  parameter int NB_LEDS_REG = 14
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_GPIOS-1:0]    i_gpo,
  output logic [NB_GPIOS-1:0]    o_gpi,
  input  logic [NB_SWITCHES-1:0] i_sw,
  output logic [11:0]            o_leds_rgb,
  output logic [1:0]             o_leds
);

  localparam int DATA_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_armed;
  logic [7:0]              r_op;
  logic [NB_LEDS_REG-1:0]  r_wdata;
  logic [NB_LEDS_REG-1:0]  r_leds;
  logic [31:0]             r_cnt;
  logic [31:0]             r_snap;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_err;
  logic                    r_ack;

  logic                    w_req;
  logic                    w_latch;
  logic                    w_exec;
  logic                    w_ack_clr;
  logic                    w_leds_we;
  logic                    w_snap_we;
  logic                    w_cnt_clr;
  logic [DATA_W-1:0]       w_rdata_nxt;
  logic                    w_err_nxt;
  logic                    w_unused;

  assign w_req = i_gpo[23];

  // Upper write-data bits and the low snapshot half are architecturally
  // present but never routed anywhere (0x03 answers straight from the counter).
  assign w_unused = ^{i_gpo[DATA_W-1:NB_LEDS_REG], r_snap[DATA_W-1:0]};

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: EXEC always lasts one cycle, ACK waits for request low
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_armed && w_req) w_state_nxt = ST_EXEC; else w_state_nxt = ST_IDLE;
      ST_EXEC: w_state_nxt = ST_ACK;
      ST_ACK:  if (!w_req) w_state_nxt = ST_IDLE; else w_state_nxt = ST_ACK;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: latch strobe, execute strobe, ack release strobe
  always_comb begin
    w_latch   = 1'b0;
    w_exec    = 1'b0;
    w_ack_clr = 1'b0;
    case (r_state)
      ST_IDLE: if (r_armed && w_req) w_latch = 1'b1; else w_latch = 1'b0;
      ST_EXEC: w_exec = 1'b1;
      ST_ACK:  if (!w_req) w_ack_clr = 1'b1; else w_ack_clr = 1'b0;
      default: w_latch = 1'b0;
    endcase
  end

  // Opcode decode of the latched command; only acted on while executing
  always_comb begin
    w_leds_we   = 1'b0;
    w_snap_we   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_rdata_nxt = {DATA_W{1'b0}};
    w_err_nxt   = 1'b0;
    case (r_op)
      8'h01: w_leds_we = 1'b1;
      8'h02: w_rdata_nxt = {{(DATA_W-NB_SWITCHES){1'b0}}, i_sw};
      8'h03: begin
        w_snap_we   = 1'b1;
        w_rdata_nxt = r_cnt[DATA_W-1:0];
      end
      8'h04: w_rdata_nxt = {14'd0, r_snap[31:DATA_W]};
      8'h05: w_cnt_clr = 1'b1;
      default: w_err_nxt = 1'b1;
    endcase
  end

  // Armed once request is seen low, so a request held through reset is ignored
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_armed <= 1'b0;
    end else if (!w_req) begin
      r_armed <= 1'b1;
    end
  end

  // Command capture; later changes on the GPO word are ignored
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op    <= 8'd0;
      r_wdata <= {NB_LEDS_REG{1'b0}};
    end else if (w_latch) begin
      r_op    <= i_gpo[31:24];
      r_wdata <= i_gpo[NB_LEDS_REG-1:0];
    end
  end

  // LED register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_leds <= {NB_LEDS_REG{1'b0}};
    end else if (w_exec && w_leds_we) begin
      r_leds <= r_wdata;
    end
  end

  // Free-running counter; wraps silently, cleared by the clear command
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= 32'd0;
    end else if (w_exec && w_cnt_clr) begin
      r_cnt <= 32'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Counter snapshot
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_snap <= 32'd0;
    end else if (w_exec && w_snap_we) begin
      r_snap <= r_cnt;
    end
  end

  // Response data/error, held until the next execute
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rdata <= {DATA_W{1'b0}};
      r_err   <= 1'b0;
    end else if (w_exec) begin
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Ack: raised as the command executes, dropped after request low is seen
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ack <= 1'b0;
    end else if (w_exec) begin
      r_ack <= 1'b1;
    end else if (w_ack_clr) begin
      r_ack <= 1'b0;
    end
  end

  assign o_gpi      = {r_ack, r_err, 7'd0, r_rdata};
  assign o_leds_rgb = r_leds[11:0];
  assign o_leds     = r_leds[13:12];

endmodule

// File: tb/tb_gpio_cmd_responder.sv
// Self-checking bench for gpio_cmd_responder: transaction-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_gpio_cmd_responder;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_gpo = 32'd0;
  logic [3:0]  i_sw = 4'd0;
  logic [31:0] o_gpi;
  logic [11:0] o_leds_rgb;
  logic [1:0]  o_leds;

  int total = 0;
  int bad = 0;

  logic [22:0] got_rd;
  logic        got_er;

  always #5 i_clk = ~i_clk;

  gpio_cmd_responder dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_gpo      (i_gpo),
    .o_gpi      (o_gpi),
    .i_sw       (i_sw),
    .o_leds_rgb (o_leds_rgb),
    .o_leds     (o_leds)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference model: what a command does, and when, from the handshake rules.
  bit        m_armed, m_pend, m_inack, m_ack, m_err;
  bit [7:0]  m_op;
  bit [13:0] m_data;
  bit [22:0] m_resp;
  bit [13:0] m_leds;
  bit [31:0] m_cnt, m_snap, m_nxt;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_armed = 0; m_pend = 0; m_inack = 0; m_ack = 0; m_err = 0;
      m_op = 0; m_data = 0; m_resp = 0; m_leds = 0; m_cnt = 0; m_snap = 0;
    end else begin
      m_nxt = m_cnt + 32'd1;
      if (m_pend) begin
        // the cycle after the latch: command takes effect, ack goes up
        m_pend = 0; m_inack = 1; m_ack = 1; m_err = 0; m_resp = 0;
        if (m_op == 8'h01) m_leds = m_data;
        else if (m_op == 8'h02) m_resp = {19'd0, i_sw};
        else if (m_op == 8'h03) begin m_snap = m_cnt; m_resp = m_cnt[22:0]; end
        else if (m_op == 8'h04) m_resp = {14'd0, m_snap[31:23]};
        else if (m_op == 8'h05) m_nxt = 32'd0;
        else m_err = 1;
      end else if (m_inack) begin
        if (!i_gpo[23]) begin m_inack = 0; m_ack = 0; end
      end else if (m_armed && i_gpo[23]) begin
        m_pend = 1; m_op = i_gpo[31:24]; m_data = i_gpo[13:0];
      end
      if (!i_gpo[23]) m_armed = 1;
      m_cnt = m_nxt;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge i_clk) begin
    if (i_reset) begin
      chk("gpi", o_gpi, {m_ack, m_err, 7'd0, m_resp});
      chk("leds_rgb", {20'd0, o_leds_rgb}, {20'd0, m_leds[11:0]});
      chk("leds_mono", {30'd0, o_leds}, {30'd0, m_leds[13:12]});
    end
  end

  // Full handshake; called at a falling edge, returns at a falling edge.
  task automatic cmd(input logic [7:0] op, input logic [22:0] data, input bit scramble);
    int k;
    i_gpo = {op, 1'b1, data};
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
      if (scramble && k == 1) i_gpo = {8'h01, 1'b1, 23'h7FFFFF};
    end while (!o_gpi[31] && k < 10);
    chk("ack_latency", k, 2);
    got_rd = o_gpi[22:0];
    got_er = o_gpi[30];
    i_gpo = 32'd0;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (o_gpi[31] && k < 10);
    chk("ack_drop", k, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_gpi", o_gpi, 32'd0);
    chk("rst_leds", {18'd0, o_leds, o_leds_rgb}, 32'd0);
    #2 i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("post_rst_gpi", o_gpi, 32'd0);

    // LED write, with the GPO word scribbled over while executing
    cmd(8'h01, 23'h002A5A, 1'b1);
    chk("w_rd", got_rd, 32'd0);
    chk("w_er", got_er, 32'd0);
    chk("w_rgb", o_leds_rgb, 32'hA5A);
    chk("w_mono", o_leds, 32'd2);

    // switch read
    i_sw = 4'b1011;
    cmd(8'h02, 23'h000000, 1'b1);
    chk("sw_rd", got_rd, 32'h00000B);
    chk("sw_er", got_er, 32'd0);
    i_sw = 4'b0100;

    // clear, then snapshot with the two requests 100 cycles apart:
    // counter is 0 the cycle after the clear executes, so snapshot = 99
    cmd(8'h05, 23'h000000, 1'b0);
    chk("clr_rd", got_rd, 32'd0);
    repeat (97) @(negedge i_clk);
    cmd(8'h03, 23'h000000, 1'b0);
    chk("snap_rd", got_rd, 32'd99);
    cmd(8'h04, 23'h000000, 1'b0);
    chk("snap_hi", got_rd, 32'd0);

    // wrap: counter forced near the top, snapshot, high half, snapshot again
    force dut.r_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_cnt;
    cmd(8'h03, 23'h000000, 1'b0);
    chk("wrap_snap1", got_rd, 32'h7FFFFF);
    chk("wrap_er", got_er, 32'd0);
    cmd(8'h04, 23'h000000, 1'b0);
    chk("wrap_hi", got_rd, 32'h0001FF);
    cmd(8'h03, 23'h000000, 1'b0);
    chk("wrap_snap2", got_rd, 32'd5);

    // request dropped while executing: ack lasts exactly one cycle
    i_gpo = {8'h02, 1'b1, 23'd0};
    @(negedge i_clk);
    i_gpo = 32'd0;
    @(negedge i_clk);
    chk("short_ack_hi", o_gpi[31], 32'd1);
    @(negedge i_clk);
    chk("short_ack_lo", o_gpi[31], 32'd0);
    @(negedge i_clk);

    // illegal opcode
    cmd(8'hFF, 23'h001234, 1'b0);
    chk("bad_er", got_er, 32'd1);
    chk("bad_rd", got_rd, 32'd0);
    chk("bad_rgb", o_leds_rgb, 32'hA5A);

    // request held high across reset release is not served
    #2 i_reset = 1'b0;
    i_gpo = {8'h01, 1'b1, 23'h000155};
    repeat (2) @(negedge i_clk);
    chk("rst2_gpi", o_gpi, 32'd0);
    chk("rst2_rgb", o_leds_rgb, 32'd0);
    #2 i_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("held_no_ack", o_gpi[31], 32'd0);
    end
    i_gpo = 32'd0;
    @(negedge i_clk);
    cmd(8'h01, 23'h000155, 1'b0);
    chk("rearm_rgb", o_leds_rgb, 32'h155);
    chk("rearm_mono", o_leds, 32'd0);

    // reset while an LED write is executing
    #2 i_reset = 1'b0;
    #2 i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_gpo = {8'h01, 1'b1, 23'h003FFF};
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("abort_rgb", o_leds_rgb, 32'd0);
    chk("abort_ack", o_gpi[31], 32'd0);
    i_gpo = 32'd0;
    #2 i_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("abort_idle", {18'd0, o_leds, o_leds_rgb}, 32'd0);
    end
    cmd(8'h01, 23'h001FFF, 1'b0);
    chk("final_rgb", o_leds_rgb, 32'hFFF);
    chk("final_mono", o_leds, 32'd1);
    repeat (2) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_cmd_responder.md
GPIO_CMD_RESPONDER -- requirements
Module: gpio_cmd_responder

Interface
REQ-001 SHALL have parameter NB_GPIOS, default 32: width of GPIO command and response words.
REQ-002 SHALL have parameter NB_SWITCHES, default 4: width of switch input.
REQ-003 SHALL have parameter NB_LEDS_REG, default 14: width of LED register (12 RGB + 2 mono).
REQ-004 SHALL have port i_clk  input  1  single clock for all logic.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_gpo  input  NB_GPIOS  command word from processor GPIO output: [31:24] opcode, [23] request, [22:0] write data.
REQ-007 SHALL have port o_gpi  output  NB_GPIOS  response word to processor GPIO input: [31] ack, [30] error, [29:23] zero, [22:0] read data.
REQ-008 SHALL have port i_sw  input  NB_SWITCHES  board switches, sampled on read only.
REQ-009 SHALL have port o_leds_rgb  output  12  RGB LEDs {rgb3,rgb2,rgb1,rgb0}, LED register bits [11:0].
REQ-010 SHALL have port o_leds  output  2  mono LEDs, LED register bits [13:12].

Function
REQ-011 SHALL run a four-phase handshake: processor raises request; block raises ack; processor drops request; block drops ack.
REQ-012 SHALL implement FSM states IDLE, EXEC, ACK.
REQ-013 In IDLE, if armed and i_gpo[23]=1, SHALL latch opcode and write data and go to EXEC.
REQ-014 In EXEC, SHALL execute the latched opcode, load response data/error registers, and go to ACK; EXEC lasts exactly one cycle.
REQ-015 In ACK, SHALL hold o_gpi[31]=1 and go to IDLE in the cycle after i_gpo[23] is sampled 0.
REQ-016 Latency: request sampled high at cycle N, so o_gpi[31]=1 registered and visible at N+2, with o_gpi[30] and o_gpi[22:0] valid in the same cycle.
REQ-017 Response data and error SHALL hold until the next EXEC; ack SHALL drop one cycle after request low is sampled.
REQ-018 Changes on i_gpo[31:24] or i_gpo[22:0] after the latch cycle SHALL be ignored until the next IDLE.
REQ-019 Opcode 0x01 (LED write) SHALL load LED register from data[13:0]; response data = 0, error = 0.
REQ-020 Opcode 0x02 (switch read) SHALL return {zeros, i_sw} as sampled in EXEC.
REQ-021 Opcode 0x03 (counter snapshot) SHALL copy the 32-bit free-running counter into the snapshot register and return snapshot[22:0].
REQ-022 Opcode 0x04 (snapshot high) SHALL return {14'b0, snapshot[31:23]} without updating the snapshot.
REQ-023 Opcode 0x05 (counter clear) SHALL zero the counter in EXEC; the counter resumes counting 1 on the following cycle; response = 0.
REQ-024 Any other opcode SHALL leave all state unchanged and return data 0 with error = 1.
REQ-025 Free-running counter SHALL increment by 1 every cycle except the clear cycle, and wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-026 Armed flag SHALL be 0 after reset and set once i_gpo[23]=1 is sampled 0; a request held high through reset SHALL NOT be processed until it drops and rises again.
REQ-027 A request that drops while in EXEC SHALL still complete; ack SHALL assert for one cycle and drop in the following cycle.
REQ-028 o_gpi[29:23] SHALL be constant 0.

Reset
REQ-029 i_reset=0 SHALL asynchronously force state IDLE, armed=0, LED register=0, counter=0, snapshot=0, response data=0, error=0, ack=0.
REQ-030 Reset asserted mid-handshake SHALL abort the command with no LED or counter update.
REQ-031 After release, all outputs SHALL remain 0 until the first completed command.

Verification
REQ-032 Write 0x01 with data 0x2A5A, request high -> ack at N+2; o_leds_rgb=0xA5A and o_leds=2'b10 from EXEC+1; ack drops one cycle after request low.
REQ-033 i_sw=4'b1011, opcode 0x02 -> o_gpi[22:0]=0x00000B, error=0.
REQ-034 Opcode 0x05, then 0x03 issued 100 cycles later -> snapshot equals the elapsed-cycle count, and a following 0x04 returns the matching high bits.
REQ-035 Force counter to 0xFFFFFFFE, snapshot twice -> wrap through 0 observed; no error.
REQ-036 Opcode 0xFF -> error=1, data=0, LEDs unchanged; request held high across reset release -> no ack until the request toggles low then high.
REQ-037 Reset asserted during EXEC of 0x01 -> LEDs stay 0 and ack stays 0.
